mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control unit of the multicycle MIPS core. A Moore-style state machine steps each instruction through fetch, decode, execute, memory and write-back. In each state it drives the datapath mux selects and write enables, including PCWrite and PCWriteCond, which the PC-select logic combines with the ALU Zero flag. Every memory-access state holds until a single-bit memory ready handshake completes.

## Interface
- No parameters; opcodes and state codes come from the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high; sampled on the rising edge of clk
- Op  in  6  opcode field, from the instruction register
- MemReady  in  1  memory completes the current read or write in this cycle
- PCWrite, PCWriteCond  out  1  PC write-enable controls, to the PC-select logic
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite, IRWrite  out  1  memory and instruction-register enables
- MemtoReg, RegDst, RegWrite  out  1  register-file write path controls
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B select: 0 = B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left by 2
- ALUOp  out  2  ALU operation: 0 = add, 1 = sub, 2 = funct-decoded
- PCSource  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- IllegalOp  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- State  out  4  current state code, for debug

## Operation
- States and their codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12 (BNE only with the macro).
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite and PCWrite are asserted only when MemReady=1; that cycle also moves to DECODE.
  - With MemReady=0, stays in FETCH.
- DECODE: drives ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by Op:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - 000101 (bne) → BNE, only with the macro
  - Any other opcode → FETCH, with IllegalOp=1 for that cycle.
- MEMADR: drives ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: drives MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: drives RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: drives MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- EXEC: drives ALUSrcA=1, ALUSrcB=0, ALUOp=2. Goes to ALUWB.
- ALUWB: drives RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH: drives ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Goes to FETCH.
- ADDIEX: drives ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to ADDIWB.
- ADDIWB: drives RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- JUMP: drives PCWrite=1, PCSource=2. Goes to FETCH.
- Any output not listed for a state is 0. Unused state codes decode to all-zero outputs and go to FETCH on the next edge.
- Op is sampled only in DECODE and MEMADR.

## Timing
- Reset:
  - reset high at a clk edge loads FETCH.
  - While reset is high, every output is forced to 0, including MemRead, and State reads 0.
  - The first FETCH with MemRead=1 is the cycle after reset is sampled low.
- Reset asserted in the middle of an instruction abandons it at the next edge. No write enable is asserted in the cycle where reset is high.
- Cycles per instruction with MemReady tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bne 3.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake rules:
  - MemRead/MemWrite and IorD stay stable for the whole wait.
  - IRWrite and PCWrite in FETCH are combinational on MemReady and occur exactly once per fetch.
  - MemReady is ignored in every other state.
- State advances only on rising edges of clk. All outputs are a combinational decode of the state, plus MemReady in FETCH, MEMRD and MEMWR.

## Configuration
- Macro: MIPS_CTRL_BNE_EN.
- Defined: adds state BNE and an extra output BranchNe (1 bit).
  - BNE drives the same outputs as BRANCH, plus BranchNe=1.
  - The PC-select logic then uses ~Zero in place of Zero.
- Undefined: there is no BNE state and no BranchNe port. Opcode 000101 is an illegal opcode (IllegalOp pulse, return to FETCH).

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - the state encoding
  - the ALUOp, ALUSrcB and PCSource encodings
- Sub-module mips_ctrl_decode: purely combinational (state, MemReady, reset) → control outputs. The top module holds the state register and the next-state logic.

## Test plan
- Reset held 3 cycles, then released, MemReady=1 → all outputs 0 during reset; next cycle State=0 with MemRead=1, IRWrite=1, PCWrite=1.
- lw (Op=100011), MemReady=1 → State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- sw with MemReady low for 2 cycles in MEMWR → MemWrite=1 and IorD=1 for 3 cycles; returns to FETCH after the MemReady=1 cycle; total 6 cycles.
- FETCH with MemReady low for 4 cycles → IRWrite and PCWrite stay 0 for those 4 cycles, then pulse once.
- beq and j → BRANCH has PCWriteCond=1, PCSource=1, ALUOp=1; JUMP has PCWrite=1, PCSource=2; each instruction takes 3 cycles.
- Op=111111 → IllegalOp pulses in DECODE, then FETCH; with the macro, Op=000101 gives State=12 and BranchNe=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, state codes and datapath select encodings for the multicycle MIPS control.
// MIPS_CTRL_BNE_EN makes opcode 000101 decode into the BNE state.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2} aluop_t;
  typedef enum logic [1:0] {SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3} srcb_t;
  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2} pcsrc_t;
  // An opcode that maps back to FETCH is illegal by definition.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXEC;
      OP_LW, OP_SW: return S_MEMADR;
      OP_BEQ:       return S_BRANCH;
      OP_ADDI:      return S_ADDIEX;
      OP_J:         return S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:       return S_BNE;
`endif
      default:      return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational control-signal decode of the state, MemReady and reset.
// MIPS_CTRL_BNE_EN adds the BranchNe output.
import mips_ctrl_pkg::*;
module mips_ctrl_decode (
  input  state_t     state,
  input  logic       MemReady,
  input  logic       reset,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
`ifdef MIPS_CTRL_BNE_EN
  , output logic     BranchNe
`endif
);
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_B;
    ALUOp = ALU_ADD;
    PCSource = PC_ALU;
`ifdef MIPS_CTRL_BNE_EN
    BranchNe = 1'b0;
`endif
    if (!reset)
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_4;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: ALUSrcB = SRCB_IMM_SH;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource = PC_ALUOUT;
        end
`ifdef MIPS_CTRL_BNE_EN
        S_BNE: begin
          ALUSrcA = 1'b1;
          ALUOp = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource = PC_ALUOUT;
          BranchNe = 1'b1;
        end
`endif
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSource = PC_JUMP;
        end
        default: ;
      endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing multicycle MIPS instructions with a MemReady handshake.
// MIPS_CTRL_BNE_EN adds the BNE state and the BranchNe output.
import mips_ctrl_pkg::*;
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
`ifdef MIPS_CTRL_BNE_EN
  , output logic     BranchNe
`endif
);
  state_t state;
  always_ff @(posedge clk)
    if (reset) state <= S_FETCH;
    else
      case (state)
        S_FETCH:  state <= MemReady ? S_DECODE : S_FETCH;
        S_DECODE: state <= decode_next(Op);
        S_MEMADR: state <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state <= MemReady ? S_MEMWB : S_MEMRD;
        S_MEMWR:  state <= MemReady ? S_FETCH : S_MEMWR;
        S_EXEC:   state <= S_ALUWB;
        S_ADDIEX: state <= S_ADDIWB;
        default:  state <= S_FETCH;
      endcase
  assign State = reset ? 4'd0 : state;
  assign IllegalOp = !reset && state == S_DECODE && decode_next(Op) == S_FETCH;
  mips_ctrl_decode u_decode (
    .state(state), .MemReady(MemReady), .reset(reset),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource)
`ifdef MIPS_CTRL_BNE_EN
    , .BranchNe(BranchNe)
`endif
  );
endmodule
